// File: rtl/fifo_uart_tx_pkg.sv
// Shared constants and FSM encoding for the FIFO-draining UART transmitter.
package fifo_uart_tx_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int FRAME_BITS_8N1   = 10;
    localparam int FRAME_BITS_8E1   = 11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_e;

    function automatic int frame_cycles(input int clks_per_bit, input bit parity_en);
        return clks_per_bit * (parity_en ? FRAME_BITS_8E1 : FRAME_BITS_8N1);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial-line status bundle of the UART transmitter.
interface fifo_uart_tx_if;
    import fifo_uart_tx_pkg::*;

    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_empty;
    logic                 fifo_re;
    logic                 tx_en;
    logic                 tx;
    logic                 busy;
    logic                 frame_done;

    modport slave (
        input  fifo_data, fifo_empty, tx_en,
        output fifo_re, tx, busy, frame_done
    );

    modport master (
        output fifo_data, fifo_empty, tx_en,
        input  fifo_re, tx, busy, frame_done
    );
endinterface

// File: rtl/fifo_uart_tx_baud_counter.sv
// Per-bit cycle counter: bit_end marks the final cycle of a bit, bit_pre_end the one before it.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end,
    output logic bit_pre_end
);
    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

    logic [W-1:0] cnt_q, cnt_d;

    assign bit_end     = (cnt_q == LAST);
    assign bit_pre_end = (cnt_q == PRE);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clear || bit_end) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter popping bytes from a show-ahead FIFO; 8N1 frames, or 8E1 when
// UART_TX_PARITY_EN is defined.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    fifo_uart_tx_if.slave  bus
);
    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]           bitcnt_q, bitcnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, frame_done_q;
    logic                 bit_end, bit_pre_end, clear, pop;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .bit_end     (bit_end),
        .bit_pre_end (bit_pre_end)
    );

    // Popping on the last stop cycle chains frames with no idle gap.
    assign pop = ~reset & bus.tx_en & ~bus.fifo_empty &
                 ((state_q == IDLE) | ((state_q == STOP) & bit_end));
    assign clear = (state_d != state_q) | (state_q == IDLE);

    assign bus.fifo_re    = pop;
    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE:  if (pop) state_d = START;
            START: if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + 3'd1;  // wraps to 0 after the last bit
                    if (bitcnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP:  if (bit_end) state_d = pop ? START : IDLE;
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shreg_d = bus.fifo_data;
`ifdef UART_TX_PARITY_EN
            parity_d = ^bus.fifo_data;
`endif
        end

        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            tx_q         <= tx_d;
            busy_q       <= (state_d != IDLE);
            // Raised one cycle early so the registered pulse lands on the last stop cycle.
            frame_done_q <= (state_q == STOP) & bit_pre_end;
`ifdef UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeding the DUT, a line decoder scoreboard and per-scenario tasks.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FC = FB * CPB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fifo_uart_tx_if u_if();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    logic [7:0] mem [0:63];
    logic [5:0] wr_ptr = '0;
    logic [5:0] rd_ptr = '0;
    assign u_if.fifo_empty = (wr_ptr == rd_ptr);
    assign u_if.fifo_data  = mem[rd_ptr];
    always @(posedge clk) if (u_if.fifo_re === 1'b1) rd_ptr <= rd_ptr + 6'd1;

    logic [7:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 6'd1;
        exp_q.push_back(b);
    endtask

    // Expected line level in cycle i (1..FC) of a frame carrying b.
    function automatic logic model_tx(input logic [7:0] b, input int i);
        int k;
        k = (i - 1) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Decodes frames off the line and pops the scoreboard at each stop bit.
    task automatic monitor();
        int cnt = 0;
        bit act = 1'b0;
        logic [7:0] got = '0;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (!act) begin
                if (!reset && u_if.tx === 1'b0) begin act = 1'b1; cnt = 1; end
            end else if (u_if.busy !== 1'b1) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                act = 1'b0;
            end else begin
                if (cnt % CPB == CPB / 2 && cnt / CPB >= 1 && cnt / CPB <= 8) got[cnt/CPB-1] = u_if.tx;
                if (cnt == FC - 1) begin
                    act = 1'b0;
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_underflow: decoded %h with nothing expected", got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp || u_if.tx !== 1'b1 || u_if.frame_done !== 1'b1) begin
                            n_fail++;
                            $display("FAIL sb_frame: byte %h stop %b done %b, want byte %h stop 1 done 1",
                                     got, u_if.tx, u_if.frame_done, exp);
                        end
                    end
                end
                cnt++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        u_if.tx_en = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (u_if.tx !== 1'b1 || u_if.busy !== 1'b0 || u_if.frame_done !== 1'b0 || u_if.fifo_re !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: tx %b busy %b done %b re %b, want 1 0 0 0",
                     u_if.tx, u_if.busy, u_if.frame_done, u_if.fifo_re);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int pops;
        u_if.tx_en = 1'b1;
        push_byte(8'h55);
        #1;
        n_tests++;
        if (u_if.fifo_re !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pop_latency: re %b want 1", u_if.fifo_re);
        end
        pops = (u_if.fifo_re === 1'b1) ? 1 : 0;
        for (int i = 1; i <= FC + 1; i++) begin
            @(negedge clk);
            if (u_if.fifo_re === 1'b1) pops++;
            n_tests++;
            if (i <= FC) begin
                if (u_if.tx !== model_tx(8'h55, i) || u_if.busy !== 1'b1 || u_if.frame_done !== (i == FC)) begin
                    n_fail++;
                    $display("FAIL single_frame c%0d: tx %b busy %b done %b, want %b 1 %b",
                             i, u_if.tx, u_if.busy, u_if.frame_done, model_tx(8'h55, i), (i == FC));
                end
            end else if (u_if.tx !== 1'b1 || u_if.busy !== 1'b0 || u_if.frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL single_idle: tx %b busy %b done %b, want 1 0 0", u_if.tx, u_if.busy, u_if.frame_done);
            end
        end
        n_tests++;
        if (pops != 1) begin
            n_fail++;
            $display("FAIL single_pop_count: %0d pops want 1", pops);
        end
    endtask

    task automatic test_back_to_back();
        int f, ii;
        logic [7:0] b;
        push_byte(8'hA5);
        push_byte(8'h3C);
        #1;
        n_tests++;
        if (u_if.fifo_re !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_pop: re %b want 1", u_if.fifo_re);
        end
        for (int i = 1; i <= 2 * FC + 1; i++) begin
            @(negedge clk);
            n_tests++;
            if (i > 2 * FC) begin
                if (u_if.busy !== 1'b0 || u_if.tx !== 1'b1 || u_if.fifo_re !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_idle: busy %b tx %b re %b, want 0 1 0", u_if.busy, u_if.tx, u_if.fifo_re);
                end
            end else begin
                f  = (i - 1) / FC;
                ii = i - f * FC;
                b  = (f == 0) ? 8'hA5 : 8'h3C;
                if (u_if.tx !== model_tx(b, ii) || u_if.busy !== 1'b1 || u_if.fifo_re !== (i == FC)) begin
                    n_fail++;
                    $display("FAIL b2b_frame c%0d: tx %b busy %b re %b, want %b 1 %b",
                             i, u_if.tx, u_if.busy, u_if.fifo_re, model_tx(b, ii), (i == FC));
                end
            end
        end
    endtask

    task automatic test_empty();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_tests++;
            if (u_if.fifo_re !== 1'b0 || u_if.tx !== 1'b1 || u_if.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_idle c%0d: re %b tx %b busy %b, want 0 1 0", i, u_if.fifo_re, u_if.tx, u_if.busy);
            end
        end
    endtask

    task automatic test_tx_en();
        push_byte(8'hFF);
        push_byte(8'h81);
        push_byte(8'h42);
        #1;
        n_tests++;
        if (u_if.fifo_re !== 1'b1) begin
            n_fail++;
            $display("FAIL txen_first_pop: re %b want 1", u_if.fifo_re);
        end
        for (int i = 1; i <= FC + 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (i <= FC) begin
                if (u_if.tx !== model_tx(8'hFF, i) || u_if.busy !== 1'b1 || u_if.fifo_re !== 1'b0 ||
                    u_if.frame_done !== (i == FC)) begin
                    n_fail++;
                    $display("FAIL txen_frame c%0d: tx %b busy %b re %b done %b, want %b 1 0 %b",
                             i, u_if.tx, u_if.busy, u_if.fifo_re, u_if.frame_done, model_tx(8'hFF, i), (i == FC));
                end
            end else if (u_if.tx !== 1'b1 || u_if.busy !== 1'b0 || u_if.fifo_re !== 1'b0) begin
                n_fail++;
                $display("FAIL txen_hold c%0d: tx %b busy %b re %b, want 1 0 0", i, u_if.tx, u_if.busy, u_if.fifo_re);
            end
            if (i == 10) u_if.tx_en = 1'b0;
        end
        u_if.tx_en = 1'b1;
        #1;
        n_tests++;
        if (u_if.fifo_re !== 1'b1) begin
            n_fail++;
            $display("FAIL txen_resume_pop: re %b want 1", u_if.fifo_re);
        end
        for (int i = 0; i < 3 * FC && !(exp_q.size() == 0 && u_if.busy === 1'b0); i++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0 || u_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL txen_drain: %0d bytes left busy %b, want 0 0", exp_q.size(), u_if.busy);
        end
    endtask

    task automatic test_reset_mid();
        push_byte(8'h0F);
        push_byte(8'h96);
        #1;
        n_tests++;
        if (u_if.fifo_re !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pop: re %b want 1", u_if.fifo_re);
        end
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (u_if.tx !== 1'b1 || u_if.busy !== 1'b0 || u_if.frame_done !== 1'b0 || u_if.fifo_re !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_state: tx %b busy %b done %b re %b, want 1 0 0 0",
                     u_if.tx, u_if.busy, u_if.frame_done, u_if.fifo_re);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (u_if.fifo_re !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_repop: re %b want 1", u_if.fifo_re);
        end
        for (int i = 1; i <= FC; i++) begin
            @(negedge clk);
            n_tests++;
            if (u_if.tx !== model_tx(8'h96, i) || u_if.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rstmid_frame c%0d: tx %b busy %b, want %b 1", i, u_if.tx, u_if.busy, model_tx(8'h96, i));
            end
        end
        for (int i = 0; i < FC && !(exp_q.size() == 0 && u_if.busy === 1'b0); i++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0 || u_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_drain: %0d bytes left busy %b, want 0 0", exp_q.size(), u_if.busy);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int f, ii;
        logic pexp;
        push_byte(8'h07);
        push_byte(8'h03);
        #1;
        for (int i = 1; i <= 2 * FC; i++) begin
            @(negedge clk);
            f  = (i - 1) / FC;
            ii = i - f * FC;
            if ((ii - 1) / CPB == 9) begin
                pexp = (f == 0) ? 1'b1 : 1'b0;
                n_tests++;
                if (u_if.tx !== pexp) begin
                    n_fail++;
                    $display("FAIL parity_bit c%0d: tx %b want %b", i, u_if.tx, pexp);
                end
            end
            n_tests++;
            if (u_if.frame_done !== (ii == FC)) begin
                n_fail++;
                $display("FAIL parity_len c%0d: done %b want %b", i, u_if.frame_done, (ii == FC));
            end
        end
        for (int i = 0; i < FC && !(exp_q.size() == 0 && u_if.busy === 1'b0); i++) @(negedge clk);
    endtask
`endif

    initial begin
        u_if.tx_en = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_empty();
        test_tx_en();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        repeat (4) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d bytes never seen on the line, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
